// File: rtl/z_mac.sv
// rtl/z_mac.sv - FP32 multiply-accumulate neuron pre-activation, one product term per cycle
//
// Computes z = bias + x[0]*w[0] + ... + x[N_IN-1]*w[N_IN-1] in that fixed order.
// Parameter: N_IN - number of input/weight pairs (2..64).
// Optional feature macro: Z_MAC_RELU_EN - adds registered relu_out alongside z.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand set handshake (x_flat, w_flat, bias)
//   x_flat, w_flat       N_IN packed FP32 values, element i at [32*i+31:32*i]
//   bias                 FP32 bias
//   out_valid / out_ready result handshake for z
//   z                    FP32 result, held until the next completion
//   z_read, back_out     back_out = last completed z when z_read=1, else 0
//   relu_out             (Z_MAC_RELU_EN only) max(z, 0), NaN and -0 map to 0
//   busy                 high while terms are being accumulated
module z_mac #(
    parameter int N_IN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*N_IN-1:0]  x_flat,
    input  logic [32*N_IN-1:0]  w_flat,
    input  logic [31:0]         bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         z,
    input  logic                z_read,
    output logic [31:0]         back_out,
`ifdef Z_MAC_RELU_EN
    output logic [31:0]         relu_out,
`endif
    output logic                busy
);
    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [32*N_IN-1:0]  x_q, w_q;
    logic [31:0]         acc, back_q, prod, sum;
    logic [IDX_W-1:0]    idx;
    logic                last;

    // FP32 multiply, round to nearest even. Subnormal operands are flushed to zero.
    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s, g, st;
        logic [47:0]       p;
        logic [23:0]       m;
        logic signed [9:0] e;
        s = a[31] ^ b[31];
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        // Rounding carry out of an all-ones fraction bumps the exponent.
        if (m[23]) begin
            m = 24'd0; e = e + 10'sd1;
        end
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
                a[30:23] == 8'h00 || b[30:23] == 8'h00)
                return 32'h7FC0_0000;
            return {s, 8'hFF, 23'd0};
        end
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0};
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    // FP32 add, round to nearest even. s carries hidden bit, fraction, guard, round, sticky.
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml;
        logic [7:0]        d;
        logic [26:0]       mb, ms, s;
        logic [53:0]       sh;
        logic [27:0]       sm;
        logic [23:0]       r;
        logic              inc;
        logic signed [9:0] e;
        if (a[30:0] >= b[30:0]) begin
            big = a; sml = b;
        end else begin
            big = b; sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 3'b000};
        sh = {1'b1, sml[22:0], 3'b000, 27'd0} >> d;
        if (d >= 8'd27) ms = 27'd1;
        else            ms = {sh[53:28], sh[27] | (|sh[26:0])};
        e = $signed({2'b00, big[30:23]});
        if (big[31] == sml[31]) begin
            sm = {1'b0, mb} + {1'b0, ms};
            if (sm[27]) begin
                s = {sm[27:2], sm[1] | sm[0]}; e = e + 10'sd1;
            end else begin
                s = sm[26:0];
            end
        end else begin
            s = mb - ms;
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && s != 27'd0) begin
                    s = s << 1; e = e - 10'sd1;
                end
            end
        end
        inc = s[2] && (s[1] || s[0] || s[3]);
        r = {1'b0, s[25:3]} + 24'(inc);
        e = e + $signed({9'd0, r[23]});
        if (big[30:23] == 8'hFF) begin
            if (big[22:0] != 23'd0 || (sml[30:23] == 8'hFF && sml[31] != big[31]))
                return 32'h7FC0_0000;
            return big;
        end
        if (sml[30:23] == 8'h00)
            return (big[30:23] == 8'h00) ? {big[31] & sml[31], 31'd0} : big;
        if (s == 27'd0) return 32'd0;
        if (e >= 10'sd255) return {big[31], 8'hFF, 23'd0};
        if (e <= 10'sd0) return {big[31], 31'd0};
        return {big[31], e[7:0], r[22:0]};
    endfunction

    assign prod     = fp32_mul(x_q[32*idx +: 32], w_q[32*idx +: 32]);
    assign sum      = fp32_add(acc, prod);
    assign last     = (idx == IDX_W'(N_IN - 1));
    assign back_out = z_read ? back_q : 32'd0;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ACC;
            end
            S_ACC: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            x_q      <= '0;
            w_q      <= '0;
            acc      <= '0;
            idx      <= '0;
            z        <= '0;
            back_q   <= '0;
`ifdef Z_MAC_RELU_EN
            relu_out <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q <= x_flat;
                        w_q <= w_flat;
                        acc <= bias;
                        idx <= '0;
                    end
                end
                S_ACC: begin
                    acc <= sum;
                    if (last) begin
                        idx    <= '0;
                        z      <= sum;
                        back_q <= sum;
`ifdef Z_MAC_RELU_EN
                        relu_out <= (!sum[31] && !(sum[30:23] == 8'hFF && sum[22:0] != 23'd0))
                                    ? sum : 32'd0;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_z_mac.sv
// tb/tb_z_mac.sv - randomized self-checking bench for z_mac against a real-arithmetic model
module tb_z_mac;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            z_read = 1'b0;
    logic            in_ready, out_valid, busy;
    logic [32*N-1:0] x_flat = '0;
    logic [32*N-1:0] w_flat = '0;
    logic [31:0]     bias = '0;
    logic [31:0]     z, back_out;
`ifdef Z_MAC_RELU_EN
    logic [31:0]     relu_out;
`endif

    int  errs = 0;
    int  checks = 0;
    real xr[N];
    real wr[N];
    real br;

    always #5 clk = ~clk;

    z_mac #(.N_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_flat    (x_flat),
        .w_flat    (w_flat),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .z_read    (z_read),
        .back_out  (back_out),
`ifdef Z_MAC_RELU_EN
        .relu_out  (relu_out),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Exact conversion; all stimulus values are small multiples of 1/4.
    function automatic logic [31:0] r2f(input real v);
        real        a;
        int         e;
        logic       s;
        logic [22:0] f;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        f = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] model_z();
        real acc;
        acc = br;
        for (int i = 0; i < N; i++) acc = acc + xr[i] * wr[i];
        return r2f(acc);
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            x_flat[32*i +: 32] = r2f(xr[i]);
            w_flat[32*i +: 32] = r2f(wr[i]);
        end
        bias = r2f(br);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            xr[i] = real'($urandom_range(0, 32)) - 16.0;
            wr[i] = (real'($urandom_range(0, 24)) - 12.0) / 4.0;
        end
        br = (real'($urandom_range(0, 160)) - 80.0) / 4.0;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            x_flat[32*i +: 32] = $urandom();
            w_flat[32*i +: 32] = $urandom();
        end
        bias     = $urandom();
        in_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input logic [31:0] expv, input bit scr, input int hold,
                         input logic [31:0] prev_back);
        int lat;
        int nbusy;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        drive_ops();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        nbusy = 0;
        while (!out_valid && lat < 40) begin
            if (busy) nbusy++;
            if (z_read) chk("back_hold", back_out, prev_back);
            if (scr) scramble();
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(N));
        chk("busy_cycles", 32'(nbusy), 32'(N));
        chk("z", z, expv);
        chk("back_out", back_out, z_read ? expv : 32'd0);
`ifdef Z_MAC_RELU_EN
        chk("relu_out", relu_out, expv[31] ? 32'd0 : expv);
`endif
        for (int h = 0; h < hold; h++) begin
            scramble();
            @(negedge clk);
            chk("bp_z_stable", z, expv);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        z_read = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_back_out", back_out, 32'd0);
        rst_n  = 1'b1;
        z_read = 1'b0;

        // 1,2,3,4 weighted by 0.5 -> 5.0, with 10 cycles of backpressure
        for (int i = 0; i < N; i++) begin xr[i] = real'(i + 1); wr[i] = 0.5; end
        br = 0.0;
        do_op(32'h40A0_0000, 1'b0, 10, 32'd0);
        chk("gate_off", back_out, 32'd0);
        z_read = 1'b1;
        #1 chk("gate_on", back_out, 32'h40A0_0000);

        // 1 - 10 = -9, operands scrambled during accumulation
        for (int i = 0; i < N; i++) wr[i] = -1.0;
        br = 1.0;
        do_op(32'hC110_0000, 1'b1, 2, 32'h40A0_0000);

        for (int i = 0; i < N; i++) wr[i] = 1.0;
        do_op(32'h4130_0000, 1'b0, 0, 32'hC110_0000);

        // Asynchronous reset two cycles into accumulation
        rand_ops();
        @(negedge clk);
        drive_ops();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_z", z, 32'd0);
        chk("abort_back_out", back_out, 32'd0);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        rand_ops();
        do_op(model_z(), 1'b1, 1, 32'd0);

        for (int t = 0; t < 25; t++) begin
            logic [31:0] prev;
            prev = back_out;
            rand_ops();
            do_op(model_z(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), prev);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
